// File: rtl/div8by4_seq.sv
// div8by4_seq: sequential restoring divider, 8-bit dividend by 4-bit divisor,
// one quotient bit per RUN cycle, valid/ready handshakes on both sides.
module div8by4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] P,
  input  logic [3:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       dz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] rem, rem_sh, rem_nx;
  logic [7:0] qsh;
  logic [3:0] div;
  logic [2:0] cnt;
  logic       qbit, accept, zpend;
  always_comb begin
    state_nx = state;
    rem_sh = {rem[3:0], qsh[7]};
    qbit = rem_sh >= {1'b0, div};
    rem_nx = qbit ? rem_sh - {1'b0, div} : rem_sh;
    in_ready = state == IDLE;
    accept = in_valid && in_ready;
    out_valid = state == DONE && !zpend;
    case (state)
      IDLE: state_nx = accept ? (B == 4'd0 ? DONE : RUN) : IDLE;
      RUN: state_nx = cnt == 3'd0 ? DONE : RUN;
      DONE: state_nx = out_valid && out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // zpend delays the divide-by-zero result by one cycle in DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      qsh <= '0;
      div <= '0;
      cnt <= '0;
      zpend <= 1'b0;
      Q <= '0;
      R <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_nx;
      zpend <= 1'b0;
      if (accept) begin
        rem <= '0;
        qsh <= P;
        div <= B;
        cnt <= 3'd7;
        if (B == 4'd0) begin
          zpend <= 1'b1;
          Q <= 8'hFF;
          R <= P[3:0];
          dz <= 1'b1;
        end
      end else if (state == RUN) begin
        rem <= rem_nx;
        qsh <= {qsh[6:0], qbit};
        cnt <= cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
        if (cnt == 3'd0) begin
          Q <= {qsh[6:0], qbit};
          R <= rem_nx[3:0];
          dz <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_div8by4_seq.sv
// tb_div8by4_seq: directed and exhaustive randomized checks of div8by4_seq
// against an arithmetic reference model.
module tb_div8by4_seq;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [7:0] P = 0;
  logic [3:0] B = 0;
  logic in_ready, out_valid, dz;
  logic [7:0] Q;
  logic [3:0] R;
  int checks = 0, errors = 0;
  int dir_tab [4][4] = '{'{200, 7, 28, 4}, '{255, 1, 255, 0}, '{15, 15, 1, 0}, '{5, 9, 0, 5}};

  always #5 clk = ~clk;

  div8by4_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .P(P), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .R(R), .dz(dz)
  );

  function automatic logic [12:0] model(input logic [7:0] p, input logic [3:0] b);
    return b == 4'd0 ? {8'hFF, p[3:0], 1'b1} : {8'(p / b), 4'(p % b), 1'b0};
  endfunction

  // Issues one operand pair and returns the first valid result, its latency
  // in edges after acceptance (-1 on timeout) and the count of busy samples.
  task automatic run_op(input logic [7:0] p, input logic [3:0] b, input logic rdy, input bit scramble,
                        output logic [12:0] got, output int lat, output int busy);
    lat = -1;
    busy = 0;
    got = '0;
    @(negedge clk);
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    P = p;
    B = b;
    in_valid = 1;
    out_ready = rdy;
    @(posedge clk);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 0) in_valid = 0;
      if (!in_ready) busy++;
      if (out_valid) begin
        lat = n;
        got = {Q, R, dz};
        break;
      end
      if (scramble) begin
        P = 8'($urandom);
        B = 4'($urandom);
        in_valid = 1'($urandom);
      end
    end
  endtask

  task automatic consume();
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {Q, R, dz} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b Q=%0d R=%0d dz=%b want rdy=1 vld=0 Q=0 R=0 dz=0",
               in_ready, out_valid, Q, R, dz);
    end
    @(negedge clk);
    rst = 0;
    P = 9;
    B = 2;
    in_valid = 1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_accept got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    in_valid = 0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {Q, R, dz} !== {8'd4, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_result got vld=%b Q=%0d R=%0d dz=%b want vld=1 Q=4 R=1 dz=0", out_valid, Q, R, dz);
    end
    consume();
  endtask

  task automatic test_directed();
    logic [12:0] got, exp;
    int lat, busy;
    for (int i = 0; i < 4; i++) begin
      exp = {8'(dir_tab[i][2]), 4'(dir_tab[i][3]), 1'b0};
      run_op(8'(dir_tab[i][0]), 4'(dir_tab[i][1]), 1, 0, got, lat, busy);
      checks++;
      if (got !== exp || lat !== 8 || busy !== 9) begin
        errors++;
        $display("FAIL directed_%0d got Q=%0d R=%0d dz=%b lat=%0d busy=%0d want Q=%0d R=%0d dz=0 lat=8 busy=9",
                 i, got[12:5], got[4:1], got[0], lat, busy, exp[12:5], exp[4:1]);
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_idle_%0d got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [12:0] got;
    int lat, busy;
    run_op(8'hA5, 4'd0, 1, 0, got, lat, busy);
    checks++;
    if (got !== {8'hFF, 4'h5, 1'b1} || lat !== 1 || busy !== 2) begin
      errors++;
      $display("FAIL div_zero got Q=%h R=%h dz=%b lat=%0d busy=%0d want Q=ff R=5 dz=1 lat=1 busy=2",
               got[12:5], got[4:1], got[0], lat, busy);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [12:0] got;
    int lat, busy;
    run_op(8'd100, 4'd3, 0, 0, got, lat, busy);
    checks++;
    if (got !== {8'd33, 4'd1, 1'b0} || lat !== 8) begin
      errors++;
      $display("FAIL bp_result got Q=%0d R=%0d dz=%b lat=%0d want Q=33 R=1 dz=0 lat=8", got[12:5], got[4:1], got[0], lat);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {Q, R, dz} !== {8'd33, 4'd1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b Q=%0d R=%0d dz=%b want vld=1 Q=33 R=1 dz=0", c, out_valid, Q, R, dz);
      end
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [12:0] got;
    int lat, busy;
    bit saw;
    @(negedge clk);
    P = 77;
    B = 5;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {Q, R, dz} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b Q=%0d R=%0d dz=%b want rdy=1 vld=0 Q=0 R=0 dz=0",
               in_ready, out_valid, Q, R, dz);
    end
    @(negedge clk);
    rst = 0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_valid got out_valid pulse=%b want 0", saw);
    end
    run_op(8'd64, 4'd8, 1, 0, got, lat, busy);
    checks++;
    if (got !== {8'd8, 4'd0, 1'b0} || lat !== 8) begin
      errors++;
      $display("FAIL after_reset got Q=%0d R=%0d dz=%b lat=%0d want Q=8 R=0 dz=0 lat=8", got[12:5], got[4:1], got[0], lat);
    end
    consume();
  endtask

  task automatic test_operand_change();
    logic [12:0] got;
    int lat, busy;
    run_op(8'd173, 4'd6, 1, 1, got, lat, busy);
    checks++;
    if (got !== {8'd28, 4'd5, 1'b0} || lat !== 8) begin
      errors++;
      $display("FAIL operand_change got Q=%0d R=%0d dz=%b lat=%0d want Q=28 R=5 dz=0 lat=8", got[12:5], got[4:1], got[0], lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    int lat, busy;
    run_op(8'd50, 4'd4, 0, 0, got, lat, busy);
    P = 9;
    B = 3;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got in_ready=%b want 0", in_ready);
    end
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {Q, R, dz} !== {8'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result got vld=%b Q=%0d R=%0d dz=%b want vld=1 Q=3 R=0 dz=0", out_valid, Q, R, dz);
    end
    consume();
  endtask

  task automatic test_exhaustive();
    logic [12:0] got, exp;
    int lat, busy, hold, want_lat;
    logic rdy;
    for (int p = 0; p < 256; p++)
      for (int b = 0; b < 16; b++) begin
        exp = model(8'(p), 4'(b));
        want_lat = b == 0 ? 1 : 8;
        rdy = 1'($urandom_range(0, 1));
        hold = rdy ? 0 : int'($urandom_range(0, 3));
        run_op(8'(p), 4'(b), rdy, 0, got, lat, busy);
        repeat (hold) @(negedge clk);
        checks++;
        if (got !== exp || lat !== want_lat || out_valid !== 1'b1 || {Q, R, dz} !== exp) begin
          errors++;
          $display("FAIL exhaustive P=%0d B=%0d got Q=%0d R=%0d dz=%b lat=%0d held=%0d/%0d/%b want Q=%0d R=%0d dz=%b lat=%0d",
                   p, b, got[12:5], got[4:1], got[0], lat, Q, R, dz, exp[12:5], exp[4:1], exp[0], want_lat);
        end
        consume();
      end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_operand_change();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div8by4_seq.md
DIV8BY4_SEQ -- requirements
Module: div8by4_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (8-bit dividend, 4-bit divisor, 8-bit quotient, 4-bit remainder), and it SHALL invert the 4x4 product path.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous reset, active-high.
REQ-005 Port: in_valid  input  1  dividend/divisor present.
REQ-006 Port: in_ready  output  1  block can accept an operand pair.
REQ-007 Port: P  input  8  dividend (unsigned product value).
REQ-008 Port: B  input  4  divisor (unsigned).
REQ-009 Port: out_valid  output  1  result present on Q/R/dz.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: Q  output  8  unsigned quotient.
REQ-012 Port: R  output  4  unsigned remainder.
REQ-013 Port: dz  output  1  divide-by-zero flag for the current result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 The block SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; at that edge P and B are latched into internal registers, and later changes on P/B are ignored.
REQ-017 On acceptance with B!=0, the FSM SHALL move IDLE->RUN, load the 5-bit partial remainder with 0, load the quotient shift register with P, and load the iteration counter with 7.
REQ-018 Each RUN cycle SHALL perform one restoring step:
  - rem = {rem[3:0], next dividend MSB};
  - if rem >= B: rem = rem - B and quotient bit = 1;
  - otherwise: quotient bit = 0.
  The quotient bit SHALL shift into the LSB.
REQ-019 RUN SHALL last exactly 8 cycles, with the counter decrementing 7..0; at counter=0 the FSM SHALL move RUN->DONE.
REQ-020 Latency: if acceptance is at edge k, out_valid SHALL first be 1 after edge k+8.
REQ-021 In DONE, the outputs SHALL be Q = floor(P/B), R = P mod B (R < B always) and dz=0.
REQ-022 On acceptance with B==0, the FSM SHALL go IDLE->DONE directly, with out_valid=1 after edge k+1, Q=8'hFF, R=P[3:0] and dz=1.
REQ-023 DONE SHALL hold Q, R and dz stable while out_ready=0, for any number of cycles.
REQ-024 A rising edge in DONE with out_ready=1 SHALL move the FSM DONE->IDLE.
REQ-025 A new operand SHALL NOT be accepted on the same edge as a DONE->IDLE transition; one IDLE cycle always separates operations.
REQ-026 in_valid SHALL be ignored outside IDLE; the block SHALL NOT queue operands.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 Q, R and dz SHALL retain the last completed result in IDLE and RUN, and update only on entry to DONE.
REQ-029 Internal arithmetic SHALL use a 5-bit remainder so that the compare/subtract never overflows; no other widening is permitted.
REQ-030 Throughput SHALL be at most one result per 10 cycles for B!=0, and one per 3 cycles for B==0.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, with in_ready=1, out_valid=0, Q=0, R=0, dz=0, counter=0 and remainder=0.
REQ-032 A reset asserted mid-RUN or in DONE SHALL discard the operation in flight; no out_valid pulse follows.
REQ-033 After rst deasserts, the first acceptance SHALL be possible on the first rising edge on which rst is low.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - P=200, B=7, out_ready=1 -> out_valid after edge k+8 with Q=28, R=4, dz=0; in_ready=0 for the 9 cycles k+1..k+9.
  - P=255, B=1 -> Q=255, R=0; P=15, B=15 -> Q=1, R=0; P=5, B=9 -> Q=0, R=5.
  - P=8'hA5, B=0 -> out_valid after edge k+1 with Q=8'hFF, R=4'h5, dz=1.
  - P=100, B=3, out_ready held 0 for 20 cycles -> Q=33, R=1 stable with out_valid=1 throughout; IDLE is reached one edge after out_ready=1.
  - rst pulsed at RUN cycle 4 -> outputs 0 immediately, no out_valid; the next op P=64, B=8 gives Q=8, R=0.
  - P/B changed and in_valid toggled during RUN -> the result still matches the originally latched operands.
REQ-035 The bench SHALL check all 256x16 operand pairs against a reference model, with random out_ready backpressure.
